// File: rtl/signed_seg_display.sv
// signed_seg_display: shows the divider quotient or remainder as a signed decimal on a 4-digit seven-segment display
module signed_seg_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_quo,
    input  logic [7:0] i_rem,
    input  logic       i_sel,
    output logic [6:0] o_seg,
    output logic [3:0] o_an,
    output logic       o_busy
);
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t      state, next_state;
    logic [7:0]  sel_val, last_val, cap, mag;
    logic        sign, disp_sign, busy_d;
    logic [11:0] bcd, bcd_adj, disp_bcd;
    logic [19:0] shifted;
    logic [2:0]  bit_cnt;
    logic [31:0] scan_cnt;
    logic        scan_wrap;
    logic [1:0]  idx;
    logic [3:0]  ones, tens, hund;
    logic [6:0]  seg_d;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = BLANK;
        endcase
    endfunction

    assign sel_val       = i_sel ? i_rem : i_quo;
    assign bcd_adj[3:0]  = (bcd[3:0]  >= 4'd5) ? bcd[3:0]  + 4'd3 : bcd[3:0];
    assign bcd_adj[7:4]  = (bcd[7:4]  >= 4'd5) ? bcd[7:4]  + 4'd3 : bcd[7:4];
    assign bcd_adj[11:8] = (bcd[11:8] >= 4'd5) ? bcd[11:8] + 4'd3 : bcd[11:8];
    assign shifted       = {bcd_adj, mag} << 1;
    assign scan_wrap     = (scan_cnt == 32'(REFRESH_DIV - 1));
    assign ones          = disp_bcd[3:0];
    assign tens          = disp_bcd[7:4];
    assign hund          = disp_bcd[11:8];

    // Conversion FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state: convert on any operand change, 8 double-dabble steps, then publish
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (sel_val != last_val) ? LOAD : IDLE;
            LOAD:    next_state = SHIFT;
            SHIFT:   next_state = (bit_cnt == 3'd7) ? DONE : SHIFT;
            default: next_state = IDLE;
        endcase
    end

    // Busy is registered from next state so it tracks the non-IDLE states exactly
    always_comb busy_d = (next_state != IDLE);

    // Conversion datapath; display registers change only in DONE so no partial value is ever shown
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_val  <= '0;
            cap       <= '0;
            sign      <= 1'b0;
            mag       <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            disp_sign <= 1'b0;
            disp_bcd  <= '0;
            o_busy    <= 1'b0;
        end else begin
            o_busy <= busy_d;
            case (state)
                IDLE: if (sel_val != last_val) begin
                    cap      <= sel_val;
                    last_val <= sel_val;
                end
                LOAD: begin
                    sign    <= cap[7];
                    mag     <= cap[7] ? 8'd0 - cap : cap;
                    bcd     <= '0;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    bcd     <= shifted[19:8];
                    mag     <= shifted[7:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                default: begin
                    disp_sign <= sign;
                    disp_bcd  <= bcd;
                end
            endcase
        end
    end

    // Refresh scanner: digit index advances once per REFRESH_DIV cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 32'd1;
            idx      <= scan_wrap ? idx + 2'd1 : idx;
        end
    end

    // Digit content with leading-zero blanking; sign always sits in the leftmost digit
    always_comb begin
        seg_d = (idx == 2'd3) ? (disp_sign ? MINUS : BLANK) :
                (idx == 2'd2) ? ((hund == 4'd0) ? BLANK : enc(hund)) :
                (idx == 2'd1) ? ((hund == 4'd0 && tens == 4'd0) ? BLANK : enc(tens)) :
                enc(ones);
    end

    // Anodes and segments registered together so they switch in the same cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_seg <= 7'h7F;
            o_an  <= 4'hF;
        end else begin
            o_seg <= seg_d;
            o_an  <= ~(4'b0001 << idx);
        end
    end
endmodule

// File: tb/tb_signed_seg_display.sv
// tb_signed_seg_display: directed vectors for the signed seven-segment display stage
module tb_signed_seg_display;
    localparam logic [6:0] BL = 7'b1111111, MI = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000;

    logic       clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic [7:0] quo = 8'd0, rem = 8'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;
    int         n_checks = 0, n_fail = 0;

    signed_seg_display #(.REFRESH_DIV(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_quo(quo), .i_rem(rem), .i_sel(sel),
        .o_seg(seg), .o_an(an), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts busy-high samples from the change until busy falls; a conversion lasts 10 cycles
    task automatic wait_conv(input string tag);
        int hi = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) begin
                hi++;
                seen = 1'b1;
            end else if (seen) break;
        end
        check({tag, "_busy_len"}, hi, 10);
    endtask

    // One full 16-cycle scan: record the segments shown under each anode
    task automatic check_scan(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] got [4];
        int bad_an = 0, busy_hi = 0;
        for (int i = 0; i < 4; i++) got[i] = 'x;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (busy) busy_hi++;
            case (an)
                4'b1110: got[0] = seg;
                4'b1101: got[1] = seg;
                4'b1011: got[2] = seg;
                4'b0111: got[3] = seg;
                default: bad_an++;
            endcase
        end
        check({tag, "_an_valid"}, bad_an, 0);
        check({tag, "_idle"}, busy_hi, 0);
        check({tag, "_dig3"}, got[3], e3);
        check({tag, "_dig2"}, got[2], e2);
        check({tag, "_dig1"}, got[1], e1);
        check({tag, "_dig0"}, got[0], e0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic b [24];
        int hi;
        #12;
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_scan("zero", BL, BL, BL, S0);

        quo = 8'd123;
        wait_conv("p123");
        check_scan("p123", BL, S1, S2, S3);

        quo = 8'hF9;
        wait_conv("m7");
        check_scan("m7", MI, BL, BL, S7);

        rem = 8'h80;
        @(negedge clk);
        @(negedge clk);
        check("rem_nosel_busy", busy, 0);
        sel = 1'b1;
        wait_conv("m128");
        check_scan("m128", MI, S1, S2, S8);

        sel = 1'b0;
        quo = 8'd45;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            b[i] = busy;
            if (i == 3) quo = 8'd67;
        end
        hi = 0;
        for (int i = 0; i < 10; i++) hi += int'(b[i]);
        check("chg_first_len", hi, 10);
        check("chg_gap", b[10], 0);
        check("chg_restart", b[11], 1);
        hi = 0;
        for (int i = 11; i < 21; i++) hi += int'(b[i]);
        check("chg_second_len", hi, 10);
        check("chg_end", b[21], 0);
        check_scan("p67", BL, BL, S6, S7);

        quo = 8'd99;
        repeat (5) @(negedge clk);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_seg", seg, 7'h7F);
        check("mid_rst_an", an, 4'hF);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_conv("r99");
        check_scan("r99", BL, BL, S9, S9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
